// File: rtl/mul_pkg.sv
// Shared types for the iterative multiplier.
//   mul_op_e    : operation select carried on op_i
//   mul_state_e : control FSM states
//   bpc_legal() : elaboration-time check of the XLEN / BITS_PER_CYC pairing
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,  // low half
    MUL_OP_MULH   = 2'b01,  // signed x signed, high half
    MUL_OP_MULHSU = 2'b10,  // signed x unsigned, high half
    MUL_OP_MULHU  = 2'b11   // unsigned x unsigned, high half
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  function automatic bit bpc_legal(input int xlen, input int bpc);
    return ((xlen == 32) || (xlen == 64)) &&
           ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
           ((xlen % bpc) == 0);
  endfunction

endpackage

// File: rtl/mul_radix_step.sv
// One iteration of the shift-add multiplier: forms the partial product of the
// unsigned multiplicand magnitude with one BITS_PER_CYC-wide multiplier digit,
// positions it at the current digit weight and adds it to the accumulator.
// Ports:
//   acc      in  2*XLEN  running accumulator
//   a_mag    in  XLEN    multiplicand magnitude
//   digit    in  BPC     current multiplier digit
//   shift    in  SH_W    bit weight of the digit
//   acc_next out 2*XLEN  accumulator after this step
module mul_radix_step #(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 2,
  parameter int SH_W         = $clog2(2 * XLEN)
) (
  input  logic [2*XLEN-1:0]       acc,
  input  logic [XLEN-1:0]         a_mag,
  input  logic [BITS_PER_CYC-1:0] digit,
  input  logic [SH_W-1:0]         shift,
  output logic [2*XLEN-1:0]       acc_next
);

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] pp;

  assign a_ext = {{XLEN{1'b0}}, a_mag};

  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (digit[i]) begin
        pp = pp + (a_ext << i);
      end
    end
    acc_next = acc + (pp << shift);
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative multi-mode integer multiplier (MUL / MULH / MULHSU / MULHU).
// Operands are converted to magnitudes on accept, multiplied unsigned over
// N = XLEN/BITS_PER_CYC CALC cycles, and the sign is applied in FIX.
// Optional build macro: MUL_ITER_EARLY_OUT_EN -- leave CALC as soon as the
// remaining multiplier bits are all zero (results unchanged, latency shorter).
// Ports:
//   clk_i         in   clock (rising edge)
//   rst_i         in   synchronous active-high reset
//   req_valid_i   in   request valid
//   req_ready_o   out  ready for a request (IDLE only)
//   op_i          in   operation select (mul_op_e encoding)
//   a_i, b_i      in   multiplicand / multiplier
//   flush_i       in   abort the operation in flight
//   resp_valid_o  out  result valid (DONE)
//   resp_ready_i  in   consumer takes the result
//   result_o      out  op-selected XLEN half of the product
//   product_o     out  full 2*XLEN product
import mul_pkg::*;

module mul_iter #(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [2*XLEN-1:0] product_o
);

  localparam int N       = XLEN / BITS_PER_CYC;
  localparam int CNT_W   = $clog2(N);
  localparam int SH_W    = $clog2(2 * XLEN);
  localparam int LOG_BPC = $clog2(BITS_PER_CYC);

  if (!bpc_legal(XLEN, BITS_PER_CYC)) begin : g_bad_cfg
    $error("mul_iter: unsupported XLEN/BITS_PER_CYC combination");
  end

  // Two's complement negate of an XLEN value when s is set. The most-negative
  // value maps onto itself, which is exactly its unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v,
                                              input logic s);
    return s ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] apply_sign(input logic signed [2*XLEN-1:0] m,
                                                   input logic n);
    return n ? -m : m;
  endfunction

  mul_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  mul_op_e           op_q;
  logic              neg_q;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   mplr;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_signed;
  logic [SH_W-1:0]   shamt;

  mul_op_e           op_in;
  logic              sign_a;
  logic              sign_b;
  logic              accept;
  logic              calc_exit;

  assign op_in  = mul_op_e'(op_i);
  assign sign_a = a_i[XLEN-1] && ((op_in == MUL_OP_MULH) || (op_in == MUL_OP_MULHSU));
  assign sign_b = b_i[XLEN-1] && (op_in == MUL_OP_MULH);
  // A flush in the request cycle blocks the accept.
  assign accept = (state == IDLE) && req_valid_i && !flush_i;

`ifdef MUL_ITER_EARLY_OUT_EN
  assign calc_exit = (mplr == '0) || (cnt == CNT_W'(N - 1));
`else
  assign calc_exit = (cnt == CNT_W'(N - 1));
`endif

  assign shamt       = SH_W'(cnt) << LOG_BPC;
  assign prod_signed = apply_sign(acc, neg_q);

  mul_radix_step #(
    .XLEN         (XLEN),
    .BITS_PER_CYC (BITS_PER_CYC),
    .SH_W         (SH_W)
  ) u_step (
    .acc      (acc),
    .a_mag    (a_mag),
    .digit    (mplr[BITS_PER_CYC-1:0]),
    .shift    (shamt),
    .acc_next (acc_step)
  );

  // ---- state register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (flush_i)        state_nxt = IDLE;
        else if (calc_exit) state_nxt = FIX;
      end
      FIX:  state_nxt = flush_i ? IDLE : DONE;
      DONE: if (flush_i || resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    req_ready_o  = (state == IDLE);
    resp_valid_o = (state == DONE);
  end

  // ---- operand capture and iteration datapath ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q  <= op_in;
      neg_q <= sign_a ^ sign_b;
      a_mag <= abs_val($signed(a_i), sign_a);
      mplr  <= abs_val($signed(b_i), sign_b);
      acc   <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      acc  <= acc_step;
      mplr <= mplr >> BITS_PER_CYC;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // ---- result registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      product_o <= '0;
      result_o  <= '0;
    end else if ((state == FIX) && !flush_i) begin
      product_o <= prod_signed;
      result_o  <= (op_q == MUL_OP_MUL) ? prod_signed[XLEN-1:0]
                                        : prod_signed[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter at XLEN=32, BITS_PER_CYC=2.
// Latency is counted with the accept cycle as cycle 1.
module tb_mul_iter;

  localparam int XLEN = 32;
  localparam int BPC  = 2;
  localparam int LAT  = XLEN / BPC + 2;

`ifdef MUL_ITER_EARLY_OUT_EN
  localparam int LAT_B0 = 3;
  localparam int LAT_B1 = 4;
`else
  localparam int LAT_B0 = LAT;
  localparam int LAT_B1 = LAT;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        op = 2'b00;
  logic [XLEN-1:0]   a = '0;
  logic [XLEN-1:0]   b = '0;
  logic              flush = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [XLEN-1:0]   result;
  logic [2*XLEN-1:0] product;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_iter #(.XLEN(XLEN), .BITS_PER_CYC(BPC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .op_i         (op),
    .a_i          (a),
    .b_i          (b),
    .flush_i      (flush),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .result_o     (result),
    .product_o    (product)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Presents one request, waits (bounded) for the
  // response, checks latency and values, and with resp_ready high checks
  // the return to IDLE on the following edge.
  task automatic run_op(input string tag, input logic [1:0] op_v,
                        input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [63:0] exp_prod, input logic [31:0] exp_res,
                        input int exp_lat);
    int lat;
    op = op_v;
    a = a_v;
    b = b_v;
    req_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) break;
      @(posedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_prod"}, product, exp_prod);
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    if (resp_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle"}, {62'd0, req_ready, resp_valid}, 64'b10);
    end
  endtask

  initial begin
    int seen;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_product", product, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mulhu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF,
           64'hFFFFFFFE_00000001, 32'hFFFFFFFE, LAT);
    run_op("mulh_minmin", 2'b01, 32'h80000000, 32'h80000000,
           64'h40000000_00000000, 32'h40000000, LAT);
    run_op("mulhsu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF,
           64'hFFFFFFFF_00000001, 32'hFFFFFFFF, LAT);
    run_op("mulh_neg_a", 2'b01, 32'hFFFFFFFF, 32'd5,
           64'hFFFFFFFF_FFFFFFFB, 32'hFFFFFFFF, LAT);
    run_op("mulh_neg_b", 2'b01, 32'd7, 32'hFFFFFFFE,
           64'hFFFFFFFF_FFFFFFF2, 32'hFFFFFFFF, LAT);
    run_op("mulh_b0", 2'b01, 32'h80000000, 32'd0,
           64'd0, 32'd0, LAT_B0);
    run_op("mulhu_b0", 2'b11, 32'hFFFFFFFF, 32'd0,
           64'd0, 32'd0, LAT_B0);

    // backpressure: MUL -3 x 7 held in DONE
    resp_ready = 1'b0;
    run_op("mul_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7,
           64'h00000006_FFFFFFEB, 32'hFFFFFFEB, LAT);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold", {31'd0, resp_valid, req_ready, result}, {31'd0, 1'b1, 1'b0, 32'hFFFFFFEB});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", {62'd0, req_ready, resp_valid}, 64'b10);

    // flush during CALC
    op = 2'b11; a = 32'd5; b = 32'd9; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {62'd0, req_ready, resp_valid}, 64'b10);
    seen = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("flush_no_resp", 64'(seen), 64'd0);
    run_op("mul_3x4", 2'b00, 32'd3, 32'd4, 64'd12, 32'd12, LAT);

    // flush in IDLE blocks a same-cycle request
    op = 2'b00; a = 32'd2; b = 32'd2; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_req", 64'(req_ready), 64'd1);

    // reset three cycles into CALC
    op = 2'b11; a = 32'hFFFFFFFF; b = 32'd3; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_valid", 64'(resp_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_product", product, 64'd0);
    run_op("mul_1000sq", 2'b00, 32'd1000, 32'd1000, 64'd1000000, 32'd1000000, LAT);

    // zero / one multiplier latency
    run_op("mul_123x0", 2'b00, 32'd123, 32'd0, 64'd0, 32'd0, LAT_B0);
    run_op("mul_123x1", 2'b00, 32'd123, 32'd1, 64'd123, 32'd123, LAT_B1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Iterative multi-mode integer multiplier for the core's M-extension execute path.
- Replaces the fixed-width, unsigned-only, level-held multiplier with a valid/ready handshake, RV32M/RV64M op modes (MUL/MULH/MULHSU/MULHU), configurable bits retired per cycle, and a flush input.
- Sits between issue and writeback; one operation in flight.

Parameters:
- XLEN, 32, operand width; 32 or 64.
- BITS_PER_CYC, 2, multiplier bits retired per CALC cycle; 1, 2 or 4; must divide XLEN.
- N (localparam), XLEN/BITS_PER_CYC, number of CALC iterations.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  block can accept a request (high only in IDLE).
- op_i  in  2  00 MUL (low), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- a_i  in  XLEN  multiplicand.
- b_i  in  XLEN  multiplier.
- flush_i  in  1  abort current operation.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  op-selected half of the product.
- product_o  out  2*XLEN  full signed/unsigned product.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, result_o=0, product_o=0.
- Accept: a request is accepted on an edge where req_valid_i && req_ready_o. On that edge, latch op, |a|, |b|, and neg=(sign_a^sign_b).
  - sign_a is the MSB of a for MULH/MULHSU, else 0.
  - sign_b is the MSB of b for MULH only, else 0.
  - MUL signedness is irrelevant; use the unsigned path.
- State IDLE -> CALC on accept.
- State CALC, count 0..N-1:
  - acc += (|a| × low BITS_PER_CYC bits of multiplier) << (count*BITS_PER_CYC).
  - Shift the multiplier right by BITS_PER_CYC.
  - After count N-1 -> FIX.
  - acc is 2*XLEN bits; the unsigned magnitude product never overflows it.
- State FIX (one cycle): product = neg ? -acc : acc (two's complement, 2*XLEN wide).
  - Register product_o and result_o: low XLEN bits for MUL, high XLEN bits otherwise.
  - Then -> DONE.
- State DONE: resp_valid_o=1; result_o and product_o held stable. On resp_ready_i -> IDLE.
- Latency: resp_valid_o rises exactly N+2 cycles after the accept edge (e.g. 18 cycles for XLEN=32, BITS_PER_CYC=2). Throughput is one op per N+3 cycles with resp_ready_i held high.
- Backpressure: DONE holds indefinitely while resp_ready_i=0. req_ready_o stays 0.
- No accept in the DONE->IDLE transition cycle; req_ready_o is registered from state.
- Flush: flush_i in CALC, FIX or DONE forces IDLE next edge with resp_valid_o=0. Flush in IDLE has no effect, and a request presented in the same cycle as flush is not accepted.
- Priority: rst_i > flush_i > handshake.
- Reset mid-operation returns to IDLE next edge and discards all state.
- Edge operands: most-negative × most-negative (MULH) is correct in 2*XLEN bits. b=0 gives product 0 for all ops, with no negative zero.

Optional Feature:
- Macro MUL_ITER_EARLY_OUT_EN.
- Defined: at the start of each CALC cycle, if the remaining shifted multiplier is all-zero, skip the add and go directly to FIX.
  - Latency is between 3 and N+2 cycles.
  - b=0 gives latency 3.
  - b=1 with BITS_PER_CYC=2 gives latency 4.
- Undefined: fixed N+2 latency with no zero detect logic. The results are identical either way.

Decomposition:
- Package mul_pkg holds:
  - the op enum (MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU);
  - the state enum (IDLE, CALC, FIX, DONE);
  - the BITS_PER_CYC legality check function.
- Sub-module mul_radix_step: combinational partial-product generator and adder for BITS_PER_CYC bits.
  - Inputs: acc, |a|, multiplier digit, shift amount.
  - Output: next acc.
  - Instantiated once.

Test Plan (XLEN=32, BITS_PER_CYC=2):
- MULHU a=0xFFFFFFFF b=0xFFFFFFFF, resp_ready_i=1 -> product_o=0xFFFFFFFE00000001, result_o=0xFFFFFFFE, resp_valid_o rises 18 cycles after accept.
- MULH a=0x80000000 b=0x80000000 -> product_o=0x4000000000000000, result_o=0x40000000. MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> product_o=0xFFFFFFFF00000001, result_o=0xFFFFFFFF.
- MUL a=0xFFFFFFFD(-3) b=7 -> result_o=0xFFFFFFEB. Then hold resp_ready_i=0 for 5 cycles -> resp_valid_o, result_o stable, req_ready_o=0; release -> IDLE next edge.
- Accept MULHU 5×9, assert flush_i at CALC cycle 5 -> IDLE next edge, no resp_valid_o. Next request 3×4 (MUL) -> result_o=12 at 18 cycles.
- Assert rst_i 3 cycles into CALC -> all outputs at reset values next edge, req_ready_o=1. A back-to-back op accepted normally.
- With MUL_ITER_EARLY_OUT_EN defined:
  - MUL a=123 b=0 -> result_o=0, latency 3.
  - b=1 -> latency 4, result_o=123.
  - Without the macro: same results, latency 18.
